// File: rtl/fetch_pkg.sv
// Shared types and constants for the MIPS instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    FETCH    = 2'd1,
    BUFFERED = 2'd2,
    DISCARD  = 2'd3
  } fetch_state_t;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int PC_INC     = 4;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Single-entry holding register for an instruction that completed while IF/ID was stalled.
module fetch_skid_buffer
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [ADDR_W-1:0]  pc4_in,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc4
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= '0;
      pc4   <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= instr_in;
      pc4   <= pc4_in;
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: owns the PC, fetches over a ready handshake, fills IF/ID; handles stalls and redirects.
module instruction_fetch_stage
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc4,
  output logic [5:0]         ifid_opcode
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] fetch_pc4;
  logic [ADDR_W-1:0] redirect_tgt;
  logic              unused_redirect_lsbs;

  logic               skid_load;
  logic               skid_clear;
  logic               skid_valid;
  logic [INSTR_W-1:0] skid_instr;
  logic [ADDR_W-1:0]  skid_pc4;

  assign fetch_pc4            = fetch_addr + ADDR_W'(PC_INC);
  assign redirect_tgt         = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Request and address are pure decodes of registers, so they stay stable until ready.
  assign imem_req    = (state == FETCH) || (state == DISCARD);
  assign imem_addr   = fetch_addr;
  assign ifid_opcode = ifid_instr[OPCODE_MSB:OPCODE_LSB];

  // NOTE: both strobes get a value on every path so no latch is inferred.
  always_comb begin
    skid_load  = !redirect && (state == FETCH) && imem_ready && stall;
    skid_clear = redirect || ((state == BUFFERED) && !stall);
  end

  fetch_skid_buffer #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .clear   (skid_clear),
    .instr_in(imem_rdata),
    .pc4_in  (fetch_pc4),
    .valid   (skid_valid),
    .instr   (skid_instr),
    .pc4     (skid_pc4)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      fetch_addr <= RESET_PC;
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
      ifid_pc4   <= '0;
    end else if (redirect) begin
      // Redirect wins over stall and over a completing fetch; that fetch's data is dropped.
      ifid_valid <= 1'b0;
      pc         <= redirect_tgt;
      unique case (state)
        FETCH: begin
          if (imem_ready) fetch_addr <= redirect_tgt;
          else            state      <= DISCARD;
        end
        DISCARD: begin
        end
        BOOT, BUFFERED: begin
          fetch_addr <= redirect_tgt;
          state      <= FETCH;
        end
      endcase
    end else begin
      unique case (state)
        BOOT: begin
          fetch_addr <= pc;
          state      <= FETCH;
        end
        FETCH: begin
          if (imem_ready && !stall) begin
            ifid_valid <= 1'b1;
            ifid_instr <= imem_rdata;
            ifid_pc4   <= fetch_pc4;
            pc         <= fetch_pc4;
            fetch_addr <= fetch_pc4;
          end else if (imem_ready) begin
            pc    <= fetch_pc4;
            state <= BUFFERED;
          end else if (!stall) begin
            ifid_valid <= 1'b0;
          end
        end
        BUFFERED: begin
          if (!stall) begin
            ifid_valid <= skid_valid;
            ifid_instr <= skid_instr;
            ifid_pc4   <= skid_pc4;
            fetch_addr <= pc;
            state      <= FETCH;
          end
        end
        DISCARD: begin
          // Drain the abandoned request at the old address before fetching the target.
          if (imem_ready) begin
            fetch_addr <= pc;
            state      <= FETCH;
          end
        end
      endcase
    end
  end

endmodule
